// File: rtl/fp_mul_round_pack.sv
// FP32 multiplier back end: normalise, round, resolve special cases, pack IEEE-754 single.
// Latency 2 clk (S1 normalise/classify, S2 round/pack); throughput 1 beat/clk.
// Backpressure: valid/ready on both sides; in_ready = !s1_v || !s2_v || out_ready.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready with in_sign_a/b, in_exp_a/b,
//        in_cls_a/b ({nan,inf,zero,normal}), in_prod (2.46 significand product);
//        out_valid/out_ready with out_word and the out_ovf/out_unf/out_inv flags.
// Build option: define FP_MUL_ROUND_RNE_EN for round-to-nearest-even; otherwise truncate.
module fp_mul_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sign_a,
    input  logic                       in_sign_b,
    input  logic [EXP_W-1:0]           in_exp_a,
    input  logic [EXP_W-1:0]           in_exp_b,
    input  logic [3:0]                 in_cls_a,
    input  logic [3:0]                 in_cls_b,
    input  logic [2*(MAN_W+1)-1:0]     in_prod,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       out_word,
    output logic                       out_ovf,
    output logic                       out_unf,
    output logic                       out_inv
);
    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int SIG_W  = MAN_W + 1;
    // Exponent carried with two extra bits so both underflow (negative) and
    // overflow (up to 2*max - bias + 2) are representable.
    localparam int EW     = EXP_W + 2;
    localparam logic [EXP_W-1:0]        EXP_MAX = '1;
    localparam logic signed [EW-1:0]    E_TOP   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]    E_ZERO  = '0;

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

    // ---------------- S1 combinational: classify and normalise ----------------
    // A zero exponent forces zero whatever the class says (no denormals).
    logic a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    assign a_zero = in_cls_a[1] || (in_exp_a == '0);
    assign b_zero = in_cls_b[1] || (in_exp_b == '0);
    assign a_nan  = in_cls_a[3] && (in_exp_a != '0);
    assign b_nan  = in_cls_b[3] && (in_exp_b != '0);
    assign a_inf  = in_cls_a[2] && (in_exp_a != '0);
    assign b_inf  = in_cls_b[2] && (in_exp_b != '0);

    spec_t spec_n;
    always_comb begin
        spec_n = SP_NONE;
        if (a_nan || b_nan)
            spec_n = SP_NAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            spec_n = SP_NAN;
        else if (a_inf || b_inf)
            spec_n = SP_INF;
        else if (a_zero || b_zero)
            spec_n = SP_ZERO;
    end

    logic signed [EW-1:0] e_n;
    assign e_n = EW'(in_exp_a) + EW'(in_exp_b) - EW'(BIAS) + EW'(in_prod[PROD_W-1]);

    // Product >= 2.0 shifts right by one; the exponent bump is folded into e_n.
    logic [SIG_W-1:0] m_n;
    logic             g_n, st_n;
    always_comb begin
        if (in_prod[PROD_W-1]) begin
            m_n  = in_prod[PROD_W-1 -: SIG_W];
            g_n  = in_prod[MAN_W];
            st_n = |in_prod[MAN_W-1:0];
        end else begin
            m_n  = in_prod[PROD_W-2 -: SIG_W];
            g_n  = in_prod[MAN_W-1];
            st_n = |in_prod[MAN_W-2:0];
        end
    end

    // ---------------- handshake ----------------
    logic s1_v, s2_adv;
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_v || s2_adv;

    // ---------------- S1 register ----------------
    logic                 s1_sign, s1_g, s1_st;
    spec_t                s1_spec;
    logic signed [EW-1:0] s1_e;
    logic [SIG_W-1:0]     s1_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_spec <= SP_NONE;
            s1_e    <= '0;
            s1_m    <= '0;
            s1_g    <= 1'b0;
            s1_st   <= 1'b0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign_a ^ in_sign_b;
                s1_spec <= spec_n;
                s1_e    <= e_n;
                s1_m    <= m_n;
                s1_g    <= g_n;
                s1_st   <= st_n;
            end
        end
    end

    // ---------------- S2 combinational: round and pack ----------------
    logic inc;
`ifdef FP_MUL_ROUND_RNE_EN
    assign inc = s1_g && (s1_st || s1_m[0]);
`else
    logic unused_round;
    assign inc          = 1'b0;
    assign unused_round = s1_g ^ s1_st;
`endif
    logic unused_cls;
    assign unused_cls = in_cls_a[0] ^ in_cls_b[0];

    // A carry out of the significand leaves the low MAN_W bits at zero, i.e. 1.0.
    logic [SIG_W:0]       m_r;
    logic signed [EW-1:0] e_r;
    assign m_r = {1'b0, s1_m} + (SIG_W + 1)'(inc);
    assign e_r = s1_e + EW'(m_r[SIG_W]);

    logic [EXP_W+MAN_W:0] res_word;
    logic                 res_ovf, res_unf, res_inv;
    always_comb begin
        res_word = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_inv  = 1'b0;
        case (s1_spec)
            SP_NAN: begin
                res_word = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
                res_inv  = 1'b1;
            end
            SP_INF:  res_word = {s1_sign, EXP_MAX, {MAN_W{1'b0}}};
            SP_ZERO: res_word = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                if (e_r >= E_TOP) begin
                    res_word = {s1_sign, EXP_MAX, {MAN_W{1'b0}}};
                    res_ovf  = 1'b1;
                end else if (e_r <= E_ZERO) begin
                    res_word = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
                    res_unf  = 1'b1;
                end else begin
                    res_word = {s1_sign, e_r[EXP_W-1:0], m_r[MAN_W-1:0]};
                end
            end
        endcase
    end

    // ---------------- S2 register (drives the outputs) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_inv   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_word <= res_word;
                out_ovf  <= res_ovf;
                out_unf  <= res_unf;
                out_inv  <= res_inv;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Bench for fp_mul_round_pack: reference model, scoreboard queue and
// handshake/stability monitor, directed corner cases and random traffic.
module tb_fp_mul_round_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        in_sign_a, in_sign_b;
    logic [7:0]  in_exp_a, in_exp_b;
    logic [3:0]  in_cls_a, in_cls_b;
    logic [47:0] in_prod;
    logic        out_valid, out_ready;
    logic [31:0] out_word;
    logic        out_ovf, out_unf, out_inv;

    always #5 clk = ~clk;

    fp_mul_round_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_cls_a(in_cls_a), .in_cls_b(in_cls_b),
        .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_ovf(out_ovf), .out_unf(out_unf), .out_inv(out_inv)
    );

    int nchk = 0;
    int npass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act === req) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    localparam logic [3:0] C_NAN = 4'b1000, C_INF = 4'b0100, C_ZERO = 4'b0010, C_NORM = 4'b0001;

    // Result packed as {inv, ovf, unf, word}.
    function automatic logic [34:0] model(input logic sa, input logic sb,
                                          input logic [7:0] ea, input logic [7:0] eb,
                                          input logic [3:0] ca, input logic [3:0] cb,
                                          input logic [47:0] prod);
        logic sg;
        bit za, zb, na, nb, ia, ib;
        int e, sh;
        longint unsigned p, m, rem, half;
        sg = sa ^ sb;
        za = ca[1] || (ea == 0);
        zb = cb[1] || (eb == 0);
        na = ca[3] && (ea != 0);
        nb = cb[3] && (eb != 0);
        ia = ca[2] && (ea != 0);
        ib = cb[2] && (eb != 0);
        if (na || nb) return {3'b100, 32'h7FC00000};
        if ((ia && zb) || (ib && za)) return {3'b100, 32'h7FC00000};
        if (ia || ib) return {3'b000, sg, 8'hFF, 23'h0};
        if (za || zb) return {3'b000, sg, 31'h0};
        e = int'(ea) + int'(eb) - 127;
        p = 64'(prod);
        if (p >= (64'd1 << 47)) begin sh = 24; e++; end
        else sh = 23;
        m    = p >> sh;
        rem  = p - (m << sh);
        half = 64'd1 << (sh - 1);
`ifdef FP_MUL_ROUND_RNE_EN
        if (rem > half || (rem == half && (m % 2) == 1)) m++;
`endif
        if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
        if (e >= 255) return {3'b010, sg, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, sg, 31'h0};
        return {3'b000, sg, e[7:0], m[22:0]};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [34:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [34:0] hold_val;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'({out_inv, out_ovf, out_unf, out_word}), 64'(hold_val));
            end
            if (exp_q.size() == 0) check("idle_valid", 64'(out_valid), 64'd0);
            check("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    $display("FAIL result: got unexpected output 0x%0h, expected none", out_word);
                end else begin
                    check("result", 64'({out_inv, out_ovf, out_unf, out_word}), 64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sign_a, in_sign_b, in_exp_a, in_exp_b,
                                      in_cls_a, in_cls_b, in_prod));
            hold_v   = out_valid && !out_ready;
            hold_val = {out_inv, out_ovf, out_unf, out_word};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [3:0] ca, input logic [3:0] cb, input logic [47:0] pr);
        in_sign_a = sa; in_sign_b = sb;
        in_exp_a = ea; in_exp_b = eb;
        in_cls_a = ca; in_cls_b = cb;
        in_prod = pr;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [3:0] ca, input logic [3:0] cb, input logic [47:0] pr);
        logic acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        drive(sa, sb, ea, eb, ca, cb, pr);
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                nchk++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic gen_rand(output logic sa, output logic sb, output logic [7:0] ea, output logic [7:0] eb,
                            output logic [3:0] ca, output logic [3:0] cb, output logic [47:0] pr);
        sa = 1'($urandom);
        sb = 1'($urandom);
        ea = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(64, 190)) : 8'($urandom_range(0, 255));
        eb = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(64, 190)) : 8'($urandom_range(0, 255));
        case ($urandom_range(0, 15))
            0: ca = C_NAN;  1: ca = C_INF;  2: ca = C_ZERO;  default: ca = C_NORM;
        endcase
        case ($urandom_range(0, 15))
            0: cb = C_NAN;  1: cb = C_INF;  2: cb = C_ZERO;  default: cb = C_NORM;
        endcase
        pr = {16'($urandom), $urandom};
        if (!pr[47]) pr[46] = 1'b1;
        if ($urandom_range(0, 3) == 0) pr[21:0] = '0;
        if ($urandom_range(0, 7) == 0) pr[46:23] = '1;
    endtask

    task automatic dir(input string name, input logic sa, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [3:0] ca, input logic [3:0] cb, input logic [47:0] pr,
                       input logic [34:0] lit);
        check({name, "_model"}, 64'(model(sa, 1'b0, ea, eb, ca, cb, pr)), 64'(lit));
        out_ready = 1'b1;
        send(sa, 1'b0, ea, eb, ca, cb, pr);
        check({name, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_lat2"}, 64'(out_valid), 64'd1);
        check(name, 64'({out_inv, out_ovf, out_unf, out_word}), 64'(lit));
        @(posedge clk); #1;
    endtask

`ifdef FP_MUL_ROUND_RNE_EN
    localparam logic [34:0] T5_LIT = {3'b000, 32'h3F800002};
    localparam logic [34:0] TC_LIT = {3'b000, 32'h40000000};
`else
    localparam logic [34:0] T5_LIT = {3'b000, 32'h3F800001};
    localparam logic [34:0] TC_LIT = {3'b000, 32'h3FFFFFFF};
`endif

    logic        r_sa, r_sb;
    logic [7:0]  r_ea, r_eb;
    logic [3:0]  r_ca, r_cb;
    logic [47:0] r_pr;
    logic        rnd_on;
    logic        saw_stall;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        in_sign_a = 1'b0; in_sign_b = 1'b0;
        in_exp_a = '0; in_exp_b = '0; in_cls_a = '0; in_cls_b = '0; in_prod = '0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_word", 64'({out_inv, out_ovf, out_unf, out_word}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases.
        dir("mul_1p5x2", 1'b0, 8'd127, 8'd128, C_NORM, C_NORM, 48'h6000_0000_0000, {3'b000, 32'h40400000});
        dir("mul_neg", 1'b1, 8'd127, 8'd128, C_NORM, C_NORM, 48'h6000_0000_0000, {3'b000, 32'hC0400000});
        dir("norm_shift", 1'b0, 8'd127, 8'd127, C_NORM, C_NORM, 48'h8000_0000_0000, {3'b000, 32'h40000000});
        dir("overflow", 1'b0, 8'd254, 8'd254, C_NORM, C_NORM, 48'h4000_0000_0000, {3'b010, 32'h7F800000});
        dir("underflow", 1'b0, 8'd60, 8'd60, C_NORM, C_NORM, 48'h4000_0000_0000, {3'b001, 32'h00000000});
        dir("inf_x_zero", 1'b0, 8'd255, 8'd0, C_INF, C_ZERO, 48'h4000_0000_0000, {3'b100, 32'h7FC00000});
        dir("nan_in", 1'b1, 8'd255, 8'd127, C_NAN, C_NORM, 48'h4000_0000_0000, {3'b100, 32'h7FC00000});
        dir("inf_x_norm", 1'b1, 8'd255, 8'd127, C_INF, C_NORM, 48'h4000_0000_0000, {3'b000, 32'hFF800000});
        dir("exp0_zero", 1'b1, 8'd0, 8'd127, C_NORM, C_NORM, 48'h4000_0000_0000, {3'b000, 32'h80000000});
        dir("round_tie", 1'b0, 8'd127, 8'd127, C_NORM, C_NORM, 48'h4000_00C0_0000, T5_LIT);
        dir("round_carry", 1'b0, 8'd127, 8'd127, C_NORM, C_NORM, 48'h7FFF_FFC0_0000, TC_LIT);

        // Four back-to-back beats, consumer stalls in cycles 3..5.
        begin
            int idx, cyc;
            logic acc;
            idx = 0; cyc = 1; saw_stall = 1'b0;
            while (idx < 4 && cyc < 50) begin
                drive(1'b0, 1'b0, 8'(120 + idx), 8'd127, C_NORM, C_NORM, 48'h5000_0000_0000 + 48'(idx));
                out_ready = !(cyc >= 3 && cyc <= 5);
                @(negedge clk);
                acc = in_ready;
                if (!in_ready) saw_stall = 1'b1;
                @(posedge clk); #1;
                if (acc) idx++;
                cyc++;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            check("burst_all_sent", 64'(idx), 64'd4);
            check("burst_stall_seen", 64'(saw_stall), 64'd1);
        end
        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin @(posedge clk); #1; guard++; end
            check("burst_drained", 64'(exp_q.size()), 64'd0);
        end

        // Reset in the middle of a burst.
        for (int i = 0; i < 3; i++) begin
            gen_rand(r_sa, r_sb, r_ea, r_eb, r_ca, r_cb, r_pr);
            send(r_sa, r_sb, r_ea, r_eb, r_ca, r_cb, r_pr);
        end
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_word", 64'({out_inv, out_ovf, out_unf, out_word}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        dir("after_rst", 1'b0, 8'd127, 8'd128, C_NORM, C_NORM, 48'h6000_0000_0000, {3'b000, 32'h40400000});

        // Random traffic with random consumer backpressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    gen_rand(r_sa, r_sb, r_ea, r_eb, r_ca, r_cb, r_pr);
                    send(r_sa, r_sb, r_ea, r_eb, r_ca, r_cb, r_pr);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
            check("final_drained", 64'(exp_q.size()), 64'd0);
        end
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
